// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequencing and result stage around the multicycle divider.
// Issues the divider start pulse, captures HI/LO on completion, flags div-by-zero and timeout.
module hilo_ctrl #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_div,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_control,
  input  logic        div_stop,
  input  logic        div_zero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic        div_timeout
);

  // state | meaning
  // IDLE  | accepting DIV / MTHI / MTLO requests
  // ISSUE | div_control high; divider samples the start at the next edge
  // WAIT  | waiting for div_stop, bounded by TIMEOUT edges
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      div_a_q, div_a_d;
  logic [31:0]      div_b_q, div_b_d;
  logic             div_control_q, div_control_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_exc_q, zero_exc_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    div_a_d       = div_a_q;
    div_b_d       = div_b_q;
    div_control_d = 1'b0;
    done_d        = 1'b0;
    zero_exc_d    = 1'b0;
    timeout_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_div) begin
          div_a_d       = rs_data;
          div_b_d       = rt_data;
          div_control_d = 1'b1;
          state_d       = ST_ISSUE;
        end else begin
          if (op_mthi) hi_d = rs_data;
          if (op_mtlo) lo_d = rs_data;
        end
      end
      // div_stop may still show the previous result here, so it is not looked at.
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_stop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (div_zero) begin
            zero_exc_d = 1'b1;
          end else begin
            hi_d = div_hi;
            lo_d = div_lo;
          end
        end else if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      div_a_q       <= '0;
      div_b_q       <= '0;
      div_control_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      zero_exc_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      div_control_q <= div_control_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      zero_exc_q    <= zero_exc_d;
      timeout_q     <= timeout_d;
    end
  end

  assign div_a        = div_a_q;
  assign div_b        = div_b_q;
  assign div_control  = div_control_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign div_zero_exc = zero_exc_q;
  assign div_timeout  = timeout_q;
  assign rd_data      = rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: transaction-level model of each divide (accept edge, latency,
// outcome) plus a stub divider; outputs are compared every cycle after each rising edge.
module tb_hilo_ctrl;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_div = 1'b0, op_mthi = 1'b0, op_mtlo = 1'b0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic [31:0] div_a, div_b;
  logic        div_control;
  logic        div_stop = 1'b0, div_zero = 1'b0;
  logic [31:0] div_hi = '0, div_lo = '0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data, hi, lo;
  logic        busy, done, div_zero_exc, div_timeout;

  always #5 clk = ~clk;

  hilo_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_div(op_div), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
    .rs_data(rs_data), .rt_data(rt_data), .div_a(div_a), .div_b(div_b),
    .div_control(div_control), .div_stop(div_stop), .div_zero(div_zero),
    .div_hi(div_hi), .div_lo(div_lo), .rd_sel(rd_sel), .rd_data(rd_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero_exc(div_zero_exc),
    .div_timeout(div_timeout)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: one divide described by its accept edge, divider latency and resulting end edge.
  int          edge_n = 0;
  bit          act_div = 0;
  int          e0 = 0, k_lat = 0, end_edge = -1;
  bit          r_zero = 0, r_tmo = 0;
  logic [31:0] res_hi = '0, res_lo = '0;
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  bit          stop_lvl = 0, held_zero = 0;
  logic [31:0] held_hi = '0, held_lo = '0;
  bit          exp_valid = 0;
  bit          exp_ctrl = 0, exp_busy = 0, exp_done = 0, exp_zero = 0, exp_tmo = 0;

  task automatic step(input bit rst, input bit d, input bit mh, input bit ml,
                      input logic [31:0] rs, input logic [31:0] rt, input int lat);
    int n;
    longint sa, sb, q, r;
    @(negedge clk);
    edge_n++;
    n = edge_n;
    reset = rst; op_div = d; op_mthi = mh; op_mtlo = ml;
    rs_data = rs; rt_data = rt;
    rd_sel = 1'($urandom_range(0, 1));

    // stub divider: div_stop rises k_lat WAIT edges after the start, then holds its level
    if (act_div && n >= e0 + 2) begin
      stop_lvl = (n - e0 - 1 >= k_lat);
      if (stop_lvl) begin
        held_hi = res_hi; held_lo = res_lo; held_zero = r_zero;
      end
    end
    div_stop = stop_lvl;
    div_hi   = stop_lvl ? held_hi : $urandom();
    div_lo   = stop_lvl ? held_lo : $urandom();
    div_zero = stop_lvl ? held_zero : 1'($urandom_range(0, 1));

    exp_ctrl = 0; exp_done = 0; exp_zero = 0; exp_tmo = 0;
    if (rst) begin
      m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
      act_div = 0; end_edge = -1; stop_lvl = 0;
    end else if (n > end_edge) begin
      if (d) begin
        act_div = 1; e0 = n; k_lat = lat;
        end_edge = n + 1 + ((lat <= TIMEOUT) ? lat : TIMEOUT);
        r_tmo = (lat > TIMEOUT);
        r_zero = (rt == 32'd0);
        m_a = rs; m_b = rt; exp_ctrl = 1;
        sa = longint'($signed(rs)); sb = longint'($signed(rt));
        if (sb != 0) begin
          q = sa / sb; r = sa % sb;
          res_lo = q[31:0]; res_hi = r[31:0];
        end else begin
          res_lo = $urandom(); res_hi = $urandom();
        end
      end else begin
        if (mh) m_hi = rs;
        if (ml) m_lo = rs;
      end
    end else if (n == end_edge) begin
      exp_done = 1;
      if (r_tmo) exp_tmo = 1;
      else if (r_zero) exp_zero = 1;
      else begin
        m_hi = res_hi; m_lo = res_lo;
      end
    end
    exp_busy = act_div && (n >= e0) && (n < end_edge);
    exp_valid = 1;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_valid) begin
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("div_a", div_a, m_a);
      chk("div_b", div_b, m_b);
      chk("rd_data", rd_data, rd_sel ? m_lo : m_hi);
      chk("div_control", 32'(div_control), 32'(exp_ctrl));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("div_zero_exc", 32'(div_zero_exc), 32'(exp_zero));
      chk("div_timeout", 32'(div_timeout), 32'(exp_tmo));
    end
  end

  task automatic idle(input int cnt);
    repeat (cnt) step(0, 0, 0, 0, $urandom(), $urandom(), 1);
  endtask

  task automatic run_to_end();
    for (int i = 0; i < 200 && edge_n < end_edge; i++) idle(1);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    idle(1);
    chk("lit_reset_hi", hi, 32'd0);
    chk("lit_reset_lo", lo, 32'd0);
    chk("lit_reset_busy", 32'(busy), 32'd0);

    step(0, 1, 0, 0, 32'd100, 32'd7, 33);
    run_to_end(); idle(2);
    chk("lit_100_7_hi", hi, 32'd2);
    chk("lit_100_7_lo", lo, 32'd14);

    step(0, 1, 0, 0, 32'hFFFF_FFF9, 32'd2, 5);
    run_to_end(); idle(2);
    chk("lit_neg7_2_hi", hi, 32'hFFFF_FFFF);
    chk("lit_neg7_2_lo", lo, 32'hFFFF_FFFD);

    step(0, 0, 1, 0, 32'h0000_AAAA, 32'd0, 1);
    step(0, 0, 0, 1, 32'h0000_5555, 32'd0, 1);
    step(0, 1, 0, 0, 32'd55, 32'd0, 2);
    run_to_end(); idle(1);
    chk("lit_dz_pulse", 32'(div_zero_exc), 32'd1);
    idle(1);
    chk("lit_dz_hi", hi, 32'h0000_AAAA);
    chk("lit_dz_lo", lo, 32'h0000_5555);

    step(0, 0, 1, 1, 32'h0000_1234, 32'd0, 1);
    idle(1);
    chk("lit_mtboth_hi", hi, 32'h0000_1234);
    chk("lit_mtboth_lo", lo, 32'h0000_1234);

    step(0, 1, 0, 0, 32'd50, 32'd6, 20);
    idle(4);
    step(0, 0, 1, 0, 32'hDEAD_BEEF, 32'd0, 1);
    run_to_end(); idle(2);
    chk("lit_busy_mthi_hi", hi, 32'd2);

    step(0, 1, 0, 1, 32'd77, 32'd9, 3);
    run_to_end(); idle(2);
    chk("lit_div_mtlo_lo", lo, 32'd8);

    // exact-boundary completion, then a timeout followed by a back-to-back divide
    step(0, 1, 0, 0, 32'd21, 32'd4, TIMEOUT);
    run_to_end(); idle(2);
    chk("lit_edge_stop_lo", lo, 32'd5);
    step(0, 1, 0, 0, 32'd11, 32'd3, TIMEOUT + 1);
    run_to_end();
    step(0, 1, 0, 0, 32'd1000, 32'd10, 7);
    chk("lit_tmo_pulse", 32'(div_timeout), 32'd1);
    chk("lit_tmo_lo", lo, 32'd5);
    run_to_end(); idle(2);
    chk("lit_after_tmo_lo", lo, 32'd100);

    step(0, 1, 0, 0, 32'd500, 32'd7, 30);
    idle(11);
    step(1, 0, 0, 0, 0, 0, 1);
    idle(1);
    chk("lit_midrst_busy", 32'(busy), 32'd0);
    chk("lit_midrst_hi", hi, 32'd0);
    step(0, 1, 0, 0, 32'd9, 32'd3, 4);
    run_to_end(); idle(2);
    chk("lit_9_3_lo", lo, 32'd3);
    chk("lit_9_3_hi", hi, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rs, rt;
      int lat;
      rs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom();
      case ($urandom_range(0, 5))
        0:       rt = 32'd0;
        1:       rt = 32'hFFFF_FFFF;
        2:       rt = 32'($urandom_range(1, 20));
        default: rt = $urandom();
      endcase
      lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                        : $urandom_range(1, 12);
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30), rs, rt, lat);
    end
    idle(2);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
